// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Brief    : ID/EX-to-muldiv operand bundle and result/stall return path.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int OP_WIDTH       = 5
);
   logic                      start;
   logic                      flush;
   logic [OP_WIDTH-1:0]       ALUOp;
   logic [DATA_WIDTH-1:0]     operandA;
   logic [DATA_WIDTH-1:0]     operandB;
   logic [REG_ADDR_WIDTH-1:0] registerFileWrite_in;
   logic                      stall;
   logic                      done;
   logic [DATA_WIDTH-1:0]     result;
   logic [DATA_WIDTH-1:0]     resultHigh;
   logic [REG_ADDR_WIDTH-1:0] registerFileWrite;
   logic                      divByZero;

   modport master (
      output start, flush, ALUOp, operandA, operandB, registerFileWrite_in,
      input  stall, done, result, resultHigh, registerFileWrite, divByZero
   );

   modport slave (
      input  start, flush, ALUOp, operandA, operandB, registerFileWrite_in,
      output stall, done, result, resultHigh, registerFileWrite, divByZero
   );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative radix-2 multiply / restoring divide for the EX stage,
//            stalling upstream while busy. Optional MULDIV_UNSIGNED_EN adds
//            unsigned multiply/divide opcodes.
// Revision : 1.0
// ============================================================================
module ex_muldiv #(
   parameter int                      DATA_WIDTH     = 32,
   parameter int                      REG_ADDR_WIDTH = 4,
   parameter int                      OP_WIDTH       = 5,
   parameter logic [OP_WIDTH-1:0]     OP_MUL         = OP_WIDTH'(12),
   parameter logic [OP_WIDTH-1:0]     OP_DIV         = OP_WIDTH'(13),
   parameter logic [OP_WIDTH-1:0]     OP_MULU        = OP_WIDTH'(14),
   parameter logic [OP_WIDTH-1:0]     OP_DIVU        = OP_WIDTH'(15)
) (
   input  logic      clock,
   input  logic      reset,
   ex_muldiv_if.slave bus
);

   localparam int              c_cnt_w = $clog2(DATA_WIDTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

   localparam logic [2:0] c_idle = 3'd0;
   localparam logic [2:0] c_mul  = 3'd1;
   localparam logic [2:0] c_div  = 3'd2;
   localparam logic [2:0] c_fix  = 3'd3;
   localparam logic [2:0] c_done = 3'd4;

   logic [2:0]                r_state;
   logic [c_cnt_w-1:0]        r_count;
   logic [DATA_WIDTH-1:0]     r_hi;
   logic [DATA_WIDTH-1:0]     r_lo;
   logic [DATA_WIDTH-1:0]     r_addend;
   logic                      r_neg_lo;
   logic                      r_neg_hi;
   logic                      r_is_div;
   logic                      r_dbz;
   logic [REG_ADDR_WIDTH-1:0] r_dest;
   logic [DATA_WIDTH-1:0]     r_result;
   logic [DATA_WIDTH-1:0]     r_result_high;
   logic [REG_ADDR_WIDTH-1:0] r_rfw;

   logic                      w_op_mul;
   logic                      w_op_div;
   logic                      w_op_mulu;
   logic                      w_op_divu;
   logic                      w_sel_mul;
   logic                      w_sel_div;
   logic                      w_unsigned;
   logic                      w_accept;
   logic                      w_a_neg;
   logic                      w_b_neg;
   logic [DATA_WIDTH-1:0]     w_a_mag;
   logic [DATA_WIDTH-1:0]     w_b_mag;
   logic                      w_b_zero;
   logic [DATA_WIDTH:0]       w_mul_sum;
   logic [DATA_WIDTH:0]       w_mul_hi;
   logic [DATA_WIDTH:0]       w_rem_sh;
   logic [DATA_WIDTH:0]       w_diff;
   logic                      w_ge;
   logic [2*DATA_WIDTH-1:0]   w_prod;
   logic [2*DATA_WIDTH-1:0]   w_prod_fix;
   logic [DATA_WIDTH-1:0]     w_quot;
   logic [DATA_WIDTH-1:0]     w_rem;

   assign w_op_mul  = (bus.ALUOp == OP_MUL);
   assign w_op_div  = (bus.ALUOp == OP_DIV);
   assign w_op_mulu = (bus.ALUOp == OP_MULU);
   assign w_op_divu = (bus.ALUOp == OP_DIVU);

`ifdef MULDIV_UNSIGNED_EN
   assign w_sel_mul  = w_op_mul | w_op_mulu;
   assign w_sel_div  = w_op_div | w_op_divu;
   assign w_unsigned = w_op_mulu | w_op_divu;
`else
   // Unsigned opcodes are decoded only to keep them out of the signed paths.
   assign w_sel_mul  = w_op_mul & ~(w_op_mulu | w_op_divu);
   assign w_sel_div  = w_op_div & ~(w_op_mulu | w_op_divu);
   assign w_unsigned = 1'b0;
`endif

   assign w_accept = ((r_state == c_idle) || (r_state == c_done)) &&
                     bus.start && !bus.flush && (w_sel_mul || w_sel_div);

   assign w_a_neg  = ~w_unsigned & bus.operandA[DATA_WIDTH-1];
   assign w_b_neg  = ~w_unsigned & bus.operandB[DATA_WIDTH-1];
   assign w_a_mag  = w_a_neg ? -bus.operandA : bus.operandA;
   assign w_b_mag  = w_b_neg ? -bus.operandB : bus.operandB;
   assign w_b_zero = (bus.operandB == '0);

   // Shift-add step: conditionally add multiplicand to the high half, then shift the pair right.
   assign w_mul_sum = {1'b0, r_hi} + {1'b0, r_addend};
   assign w_mul_hi  = r_lo[0] ? w_mul_sum : {1'b0, r_hi};

   // Restoring step: the extra bit of w_diff is the borrow, i.e. "partial remainder < divisor".
   assign w_rem_sh = {r_hi, r_lo[DATA_WIDTH-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_addend};
   assign w_ge     = ~w_diff[DATA_WIDTH];

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
   assign w_quot     = r_neg_lo ? -r_lo : r_lo;
   assign w_rem      = r_neg_hi ? -r_hi : r_hi;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= c_idle;
         r_count       <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_addend      <= '0;
         r_neg_lo      <= 1'b0;
         r_neg_hi      <= 1'b0;
         r_is_div      <= 1'b0;
         r_dbz         <= 1'b0;
         r_dest        <= '0;
         r_result      <= '0;
         r_result_high <= '0;
         r_rfw         <= '0;
      end else begin
         r_dbz <= 1'b0;
         if (bus.flush) begin
            r_state <= c_idle;
         end else begin
            case (r_state)
               c_idle, c_done: begin
                  if (w_accept) begin
                     r_dest   <= bus.registerFileWrite_in;
                     r_count  <= '0;
                     r_neg_lo <= w_a_neg ^ w_b_neg;
                     r_neg_hi <= w_a_neg;
                     r_is_div <= w_sel_div;
                     r_hi     <= '0;
                     if (w_sel_div && w_b_zero) begin
                        r_result      <= '1;
                        r_result_high <= bus.operandA;
                        r_rfw         <= bus.registerFileWrite_in;
                        r_dbz         <= 1'b1;
                        r_state       <= c_done;
                     end else if (w_sel_div) begin
                        r_lo     <= w_a_mag;
                        r_addend <= w_b_mag;
                        r_state  <= c_div;
                     end else begin
                        r_lo     <= w_b_mag;
                        r_addend <= w_a_mag;
                        r_state  <= c_mul;
                     end
                  end else begin
                     r_state <= c_idle;
                  end
               end
               c_mul: begin
                  r_hi    <= w_mul_hi[DATA_WIDTH:1];
                  r_lo    <= {w_mul_hi[0], r_lo[DATA_WIDTH-1:1]};
                  r_count <= r_count + 1'b1;
                  if (r_count == c_last) r_state <= c_fix;
               end
               c_div: begin
                  r_hi    <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
                  r_lo    <= {r_lo[DATA_WIDTH-2:0], w_ge};
                  r_count <= r_count + 1'b1;
                  if (r_count == c_last) r_state <= c_fix;
               end
               c_fix: begin
                  if (r_is_div) begin
                     r_result      <= w_quot;
                     r_result_high <= w_rem;
                  end else begin
                     {r_result_high, r_result} <= w_prod_fix;
                  end
                  r_rfw   <= r_dest;
                  r_state <= c_done;
               end
               default: r_state <= c_idle;
            endcase
         end
      end
   end

   assign bus.stall             = (r_state == c_mul) || (r_state == c_div) || (r_state == c_fix);
   assign bus.done              = (r_state == c_done);
   assign bus.result            = r_result;
   assign bus.resultHigh        = r_result_high;
   assign bus.registerFileWrite = r_rfw;
   assign bus.divByZero         = r_dbz;

endmodule
`default_nettype wire
